// File: rtl/store_buffer.sv
// Store buffer in front of single-port data memory: FIFO of pending stores drained when no load
// needs the port, with youngest-match forwarding into a registered load result.
module store_buffer #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         st_valid,
  input  logic [ADDR_WIDTH-1:0]        st_addr,
  input  logic [DATA_WIDTH-1:0]        st_data,
  output logic                         st_ready,
  input  logic                         ld_valid,
  input  logic [ADDR_WIDTH-1:0]        ld_addr,
  output logic                         ld_rvalid,
  output logic [DATA_WIDTH-1:0]        ld_rdata,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ld_rvalid_q, ld_rvalid_d;
  logic [DATA_WIDTH-1:0] ld_rdata_q, ld_rdata_d;

  logic                  push, pop;
  logic [PTR_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] sel_data;

  assign st_ready  = (count_q != FULL_CNT);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign ld_rvalid = ld_rvalid_q;
  assign ld_rdata  = ld_rdata_q;

  // Port arbitration, forwarding and FIFO next-state.
  always_comb begin
    addr_d      = addr_q;
    data_d      = data_q;
    valid_d     = valid_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    idx         = '0;
    sel_data    = mem_rdata;

    push = st_valid && (count_q != FULL_CNT);
    pop  = !ld_valid && (count_q != '0);

    if (!rst) begin
      if (ld_valid) begin
        mem_read = 1'b1;
        mem_addr = ld_addr;
      end else if (pop) begin
        mem_write = 1'b1;
        mem_addr  = addr_q[head_q];
        mem_wdata = data_q[head_q];
      end
    end

    // Walk oldest to youngest so the last hit is the youngest matching store.
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx] == ld_addr)) begin
        sel_data = data_q[idx];
      end
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push) begin
      addr_d[tail_q]  = st_addr;
      data_d[tail_q]  = st_data;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    ld_rvalid_d = ld_valid;
    ld_rdata_d  = ld_valid ? sel_data : ld_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ld_rvalid_q <= 1'b0;
      ld_rdata_q  <= '0;
    end else begin
      valid_q     <= valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ld_rvalid_q <= ld_rvalid_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // Payload storage needs no reset; valid bits guard it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_q[i] <= addr_d[i];
      data_q[i] <= data_d[i];
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed, table-driven bench for store_buffer with a behavioural data memory.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [3:0]  st_addr;
  logic [15:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [3:0]  ld_addr;
  logic        ld_rvalid;
  logic [15:0] ld_rdata;
  logic        empty;
  logic [2:0]  count;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  logic [15:0] mem [16];
  logic        mem_init;
  int          n_wr;
  int          n_vec;
  int          n_miss;
  int          cur;

  always #5 clk = ~clk;

  store_buffer #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .empty(empty), .count(count),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem_read ? mem[mem_addr] : 16'h0000;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'hA000 + 16'(i);
      mem[5] <= 16'h0000;
      mem[7] <= 16'h00AA;
      n_wr   <= 0;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
      n_wr          <= n_wr + 1;
    end
  end

  typedef struct {
    logic        rst;
    logic        stv;
    logic [3:0]  sta;
    logic [15:0] std;
    logic        ldv;
    logic [3:0]  lda;
    logic        rdy;
    logic        emp;
    logic [2:0]  cnt;
    logic        rv;
    logic [15:0] rd;
    logic        mrd;
    logic        mwr;
    logic [3:0]  ma;
    logic [15:0] mw;
  } vec_t;

  localparam int NV = 34;
  vec_t tbl [NV];

  function automatic vec_t mk(logic r, logic sv, logic [3:0] sa, logic [15:0] sd,
                              logic lv, logic [3:0] la, logic rdy, logic emp,
                              logic [2:0] cnt, logic rv, logic [15:0] rd,
                              logic mrd, logic mwr, logic [3:0] ma, logic [15:0] mw);
    vec_t v;
    v.rst = r;   v.stv = sv;  v.sta = sa;  v.std = sd;  v.ldv = lv;  v.lda = la;
    v.rdy = rdy; v.emp = emp; v.cnt = cnt; v.rv = rv;   v.rd = rd;
    v.mrd = mrd; v.mwr = mwr; v.ma = ma;   v.mw = mw;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL step %0d %s: got %h expected %h", cur, nm, act, exp);
    end
  endtask

  initial begin
    // Expected columns: registered outputs reflect prior edges, mem_* reflect this cycle.
    //             rst st sa  sd        ld la    rdy emp cnt rv rd        mrd mwr ma   mw
    tbl[0]  = mk(1, 1, 2, 16'h2222, 1, 4,    1, 1, 0, 0, 16'h0000, 0, 0, 0,   16'h0000);
    tbl[1]  = mk(0, 0, 0, 16'h0000, 0, 0,    1, 1, 0, 0, 16'h0000, 0, 0, 0,   16'h0000);
    tbl[2]  = mk(0, 1, 3, 16'hBEEF, 0, 0,    1, 1, 0, 0, 16'h0000, 0, 0, 0,   16'h0000);
    tbl[3]  = mk(0, 0, 0, 16'h0000, 0, 0,    1, 0, 1, 0, 16'h0000, 0, 1, 3,   16'hBEEF);
    tbl[4]  = mk(0, 0, 0, 16'h0000, 0, 0,    1, 1, 0, 0, 16'h0000, 0, 0, 0,   16'h0000);
    tbl[5]  = mk(0, 0, 0, 16'h0000, 1, 3,    1, 1, 0, 0, 16'h0000, 1, 0, 3,   16'h0000);
    tbl[6]  = mk(0, 0, 0, 16'h0000, 0, 0,    1, 1, 0, 1, 16'hBEEF, 0, 0, 0,   16'h0000);
    tbl[7]  = mk(0, 1, 5, 16'h1111, 1, 15,   1, 1, 0, 0, 16'hBEEF, 1, 0, 15,  16'h0000);
    tbl[8]  = mk(0, 1, 5, 16'h2222, 1, 15,   1, 0, 1, 1, 16'hA00F, 1, 0, 15,  16'h0000);
    tbl[9]  = mk(0, 0, 0, 16'h0000, 1, 5,    1, 0, 2, 1, 16'hA00F, 1, 0, 5,   16'h0000);
    tbl[10] = mk(0, 0, 0, 16'h0000, 1, 15,   1, 0, 2, 1, 16'h2222, 1, 0, 15,  16'h0000);
    tbl[11] = mk(0, 1, 8, 16'h0808, 1, 15,   1, 0, 2, 1, 16'hA00F, 1, 0, 15,  16'h0000);
    tbl[12] = mk(0, 1, 9, 16'h0909, 1, 15,   1, 0, 3, 1, 16'hA00F, 1, 0, 15,  16'h0000);
    tbl[13] = mk(0, 1, 10, 16'h0A0A, 1, 15,  0, 0, 4, 1, 16'hA00F, 1, 0, 15,  16'h0000);
    tbl[14] = mk(0, 1, 11, 16'h0B0B, 0, 0,   0, 0, 4, 1, 16'hA00F, 0, 1, 5,   16'h1111);
    tbl[15] = mk(0, 0, 0, 16'h0000, 0, 0,    1, 0, 3, 0, 16'hA00F, 0, 1, 5,   16'h2222);
    tbl[16] = mk(0, 0, 0, 16'h0000, 0, 0,    1, 0, 2, 0, 16'hA00F, 0, 1, 8,   16'h0808);
    tbl[17] = mk(0, 0, 0, 16'h0000, 0, 0,    1, 0, 1, 0, 16'hA00F, 0, 1, 9,   16'h0909);
    tbl[18] = mk(0, 0, 0, 16'h0000, 0, 0,    1, 1, 0, 0, 16'hA00F, 0, 0, 0,   16'h0000);
    tbl[19] = mk(0, 1, 7, 16'h5555, 1, 7,    1, 1, 0, 0, 16'hA00F, 1, 0, 7,   16'h0000);
    tbl[20] = mk(0, 0, 0, 16'h0000, 1, 7,    1, 0, 1, 1, 16'h00AA, 1, 0, 7,   16'h0000);
    tbl[21] = mk(0, 0, 0, 16'h0000, 0, 0,    1, 0, 1, 1, 16'h5555, 0, 1, 7,   16'h5555);
    tbl[22] = mk(0, 1, 1, 16'h0101, 0, 0,    1, 1, 0, 0, 16'h5555, 0, 0, 0,   16'h0000);
    tbl[23] = mk(0, 1, 2, 16'h0202, 0, 0,    1, 0, 1, 0, 16'h5555, 0, 1, 1,   16'h0101);
    tbl[24] = mk(0, 0, 0, 16'h0000, 0, 0,    1, 0, 1, 0, 16'h5555, 0, 1, 2,   16'h0202);
    tbl[25] = mk(0, 1, 12, 16'h0C0C, 0, 0,   1, 1, 0, 0, 16'h5555, 0, 0, 0,   16'h0000);
    tbl[26] = mk(0, 1, 13, 16'h0D0D, 1, 12,  1, 0, 1, 0, 16'h5555, 1, 0, 12,  16'h0000);
    tbl[27] = mk(0, 1, 14, 16'h0E0E, 1, 15,  1, 0, 2, 1, 16'h0C0C, 1, 0, 15,  16'h0000);
    tbl[28] = mk(1, 0, 0, 16'h0000, 1, 15,   1, 0, 3, 1, 16'hA00F, 0, 0, 0,   16'h0000);
    tbl[29] = mk(0, 0, 0, 16'h0000, 0, 0,    1, 1, 0, 0, 16'h0000, 0, 0, 0,   16'h0000);
    tbl[30] = mk(0, 0, 0, 16'h0000, 1, 12,   1, 1, 0, 0, 16'h0000, 1, 0, 12,  16'h0000);
    tbl[31] = mk(0, 0, 0, 16'h0000, 0, 0,    1, 1, 0, 1, 16'hA00C, 0, 0, 0,   16'h0000);
    tbl[32] = mk(0, 0, 0, 16'h0000, 1, 10,   1, 1, 0, 0, 16'hA00C, 1, 0, 10,  16'h0000);
    tbl[33] = mk(0, 0, 0, 16'h0000, 0, 0,    1, 1, 0, 1, 16'hA00A, 0, 0, 0,   16'h0000);

    n_vec = 0; n_miss = 0; cur = 0;
    rst = 1'b1; mem_init = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0; ld_valid = 1'b0; ld_addr = '0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      mem_init = 1'b0;
      rst      = tbl[k].rst;
      st_valid = tbl[k].stv;
      st_addr  = tbl[k].sta;
      st_data  = tbl[k].std;
      ld_valid = tbl[k].ldv;
      ld_addr  = tbl[k].lda;
      #1;
      cur = k;
      n_vec++;
      chk("st_ready",  32'(st_ready),  32'(tbl[k].rdy));
      chk("empty",     32'(empty),     32'(tbl[k].emp));
      chk("count",     32'(count),     32'(tbl[k].cnt));
      chk("ld_rvalid", 32'(ld_rvalid), 32'(tbl[k].rv));
      chk("ld_rdata",  32'(ld_rdata),  32'(tbl[k].rd));
      chk("mem_read",  32'(mem_read),  32'(tbl[k].mrd));
      chk("mem_write", 32'(mem_write), 32'(tbl[k].mwr));
      chk("mem_addr",  32'(mem_addr),  32'(tbl[k].ma));
      chk("mem_wdata", 32'(mem_wdata), 32'(tbl[k].mw));
    end

    // Back-to-back duplicate-address stores: both drain, last one wins.
    begin
      int wr0;
      bit seen_empty;
      cur = NV;
      wr0 = n_wr;
      @(negedge clk); st_valid = 1'b1; st_addr = 4'd6; st_data = 16'h0606; ld_valid = 1'b0;
      @(negedge clk); st_addr = 4'd6; st_data = 16'h6060;
      @(negedge clk); st_valid = 1'b0;
      seen_empty = 1'b0;
      for (int c = 0; c < 10 && !seen_empty; c++) begin
        @(negedge clk);
        if (empty === 1'b1) seen_empty = 1'b1;
      end
      n_vec++;
      chk("drain_timeout", 32'(seen_empty), 32'd1);
      n_vec++;
      chk("dup_writes", 32'(n_wr - wr0), 32'd2);
    end

    // Final memory image.
    cur = NV + 1;
    n_vec++; chk("mem[1]",  32'(mem[1]),  32'h0101);
    n_vec++; chk("mem[2]",  32'(mem[2]),  32'h0202);
    n_vec++; chk("mem[3]",  32'(mem[3]),  32'hBEEF);
    n_vec++; chk("mem[5]",  32'(mem[5]),  32'h2222);
    n_vec++; chk("mem[6]",  32'(mem[6]),  32'h6060);
    n_vec++; chk("mem[7]",  32'(mem[7]),  32'h5555);
    n_vec++; chk("mem[8]",  32'(mem[8]),  32'h0808);
    n_vec++; chk("mem[9]",  32'(mem[9]),  32'h0909);
    n_vec++; chk("mem[10]", 32'(mem[10]), 32'hA00A);
    n_vec++; chk("mem[11]", 32'(mem[11]), 32'hA00B);
    n_vec++; chk("mem[12]", 32'(mem[12]), 32'hA00C);
    n_vec++; chk("mem[13]", 32'(mem[13]), 32'hA00D);
    n_vec++; chk("mem[14]", 32'(mem[14]), 32'hA00E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
